// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch-to-decode instruction queue.
// Contents: XLEN, NOP_INSTR, register-field slice positions, fetch_pkt_t, NOP_PKT.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;
  localparam int REG_W = 5;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int RD_LSB = 7;
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcplus4;
    logic pred_taken;
  } fetch_pkt_t;
  localparam fetch_pkt_t NOP_PKT = '{instr: NOP_INSTR, pc: '0, pcplus4: '0, pred_taken: 1'b0};
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular buffer between fetch and decode, flushed in one cycle on mispredict.
// Ports: clk, rst (sync, active-high), flush_i; fetch side f_valid_i/f_ready_o + packet fields;
// decode side d_valid_o/d_ready_i, head packet fields, decoded rs1/rs2/rd; count_o occupancy.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic flush_i,
  input  logic f_valid_i,
  input  logic [DATA_WIDTH-1:0] f_instr_i,
  input  logic [DATA_WIDTH-1:0] f_pc_i,
  input  logic [DATA_WIDTH-1:0] f_pcplus4_i,
  input  logic f_pred_taken_i,
  output logic f_ready_o,
  output logic d_valid_o,
  input  logic d_ready_i,
  output logic [DATA_WIDTH-1:0] d_instr_o,
  output logic [DATA_WIDTH-1:0] d_pc_o,
  output logic [DATA_WIDTH-1:0] d_pcplus4_o,
  output logic d_pred_taken_o,
  output logic [REG_W-1:0] d_rs1_o,
  output logic [REG_W-1:0] d_rs2_o,
  output logic [REG_W-1:0] d_rd_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr, rd_ptr;
  fetch_pkt_t mem [DEPTH];
  fetch_pkt_t head;
  logic empty, full, push, pop;
  assign empty = wr_ptr == rd_ptr;
  // MSB is the wrap flag: same index with differing wrap means the writer lapped the reader
  assign full = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign f_ready_o = !full;
  assign d_valid_o = !empty;
  assign push = f_valid_i && f_ready_o;
  assign pop = d_valid_o && d_ready_i;
  assign count_o = wr_ptr - rd_ptr;
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  // Storage is never cleared; validity comes solely from the pointers
  always_ff @(posedge clk) begin
    if (push && !rst && !flush_i)
      mem[wr_ptr[AW-1:0]] <= '{instr: f_instr_i, pc: f_pc_i, pcplus4: f_pcplus4_i, pred_taken: f_pred_taken_i};
  end
  assign head = empty ? NOP_PKT : mem[rd_ptr[AW-1:0]];
  assign d_instr_o = head.instr;
  assign d_pc_o = head.pc;
  assign d_pcplus4_o = head.pcplus4;
  assign d_pred_taken_o = head.pred_taken;
  assign d_rs1_o = head.instr[RS1_LSB +: REG_W];
  assign d_rs2_o = head.instr[RS2_LSB +: REG_W];
  assign d_rd_o = head.instr[RD_LSB +: REG_W];
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus with a scoreboard monitor checking fetch_queue every cycle.
module tb_fetch_queue;
  import fetch_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b1, flush_i = 1'b0, f_valid_i = 1'b0, f_pred_taken_i = 1'b0, d_ready_i = 1'b0;
  logic [31:0] f_instr_i = '0, f_pc_i = '0, f_pcplus4_i = '0;
  logic f_ready_o, d_valid_o, d_pred_taken_o;
  logic [31:0] d_instr_o, d_pc_o, d_pcplus4_o;
  logic [4:0] d_rs1_o, d_rs2_o, d_rd_o;
  logic [2:0] count_o;
  int checks = 0, errors = 0;
  bit mon_on = 1'b0;
  fetch_pkt_t sb [$];

  fetch_queue #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .f_valid_i(f_valid_i), .f_instr_i(f_instr_i),
    .f_pc_i(f_pc_i), .f_pcplus4_i(f_pcplus4_i), .f_pred_taken_i(f_pred_taken_i),
    .f_ready_o(f_ready_o), .d_valid_o(d_valid_o), .d_ready_i(d_ready_i), .d_instr_o(d_instr_o),
    .d_pc_o(d_pc_o), .d_pcplus4_o(d_pcplus4_o), .d_pred_taken_o(d_pred_taken_o),
    .d_rs1_o(d_rs1_o), .d_rs2_o(d_rs2_o), .d_rd_o(d_rd_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: compares head/flags against the scoreboard, then advances the scoreboard
  // with what the coming edge should do given the inputs now applied.
  always @(negedge clk) begin
    if (mon_on) begin
      fetch_pkt_t e;
      int n;
      bit do_pop, do_push;
      n = sb.size();
      e = (n == 0) ? '{instr: 32'h00000013, pc: '0, pcplus4: '0, pred_taken: 1'b0} : sb[0];
      chk("count", 32'(count_o), 32'(n));
      chk("f_ready", 32'(f_ready_o), 32'(n < DEPTH));
      chk("d_valid", 32'(d_valid_o), 32'(n != 0));
      chk("instr", d_instr_o, e.instr);
      chk("pc", d_pc_o, e.pc);
      chk("pcplus4", d_pcplus4_o, e.pcplus4);
      chk("pred", 32'(d_pred_taken_o), 32'(e.pred_taken));
      chk("rs1", 32'(d_rs1_o), 32'(e.instr[19:15]));
      chk("rs2", 32'(d_rs2_o), 32'(e.instr[24:20]));
      chk("rd", 32'(d_rd_o), 32'(e.instr[11:7]));
      if (rst || flush_i) sb.delete();
      else begin
        do_pop = (n != 0) && d_ready_i;
        do_push = f_valid_i && (n < DEPTH);
        if (do_pop) void'(sb.pop_front());
        if (do_push) sb.push_back('{instr: f_instr_i, pc: f_pc_i, pcplus4: f_pcplus4_i, pred_taken: f_pred_taken_i});
      end
    end
  end

  task automatic step(bit v, logic [31:0] pc, bit tk, bit rdy, bit fl = 1'b0, bit r = 1'b0);
    @(posedge clk);
    #1;
    f_valid_i = v;
    f_pc_i = pc;
    f_pcplus4_i = pc + 32'd4;
    f_instr_i = pc ^ 32'h5A3C_96F3;
    f_pred_taken_i = tk;
    d_ready_i = rdy;
    flush_i = fl;
    rst = r;
  endtask

  task automatic at_neg(string name, logic [31:0] act_sel, logic [31:0] exp);
    chk(name, act_sel, exp);
  endtask

  initial begin
    @(posedge clk);
    #1;
    mon_on = 1'b1;
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    @(negedge clk);
    chk("reset_instr", d_instr_o, 32'h00000013);
    chk("reset_count", 32'(count_o), 0);
    // fill with decode stalled; fifth push refused
    for (int i = 0; i < 5; i++) step(1, 32'hBFC00000 + 32'(4 * i), i[0], 0);
    step(0, 0, 0, 0);
    @(negedge clk);
    chk("full_count", 32'(count_o), 4);
    chk("full_ready", 32'(f_ready_o), 0);
    chk("full_head_pc", d_pc_o, 32'hBFC00000);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
    @(negedge clk);
    chk("drained", 32'(count_o), 0);
    // streaming through the pointer wrap
    for (int i = 0; i < 12; i++) begin
      step(1, 32'hBFC00100 + 32'(4 * i), i[1], 1);
      if (i == 6) begin
        @(negedge clk);
        chk("stream_count", 32'(count_o), 1);
        chk("stream_pc", d_pc_o, 32'hBFC00114);
      end
    end
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    @(negedge clk);
    chk("stream_end", 32'(count_o), 0);
    // flush at occupancy 3 with push and pop in the same cycle
    for (int i = 0; i < 3; i++) step(1, 32'hBFC00200 + 32'(4 * i), 0, 0);
    step(1, 32'hBFC00300, 1, 1, 1);
    step(1, 32'hBFC00040, 1, 0);
    @(negedge clk);
    chk("flush_count", 32'(count_o), 0);
    chk("flush_valid", 32'(d_valid_o), 0);
    step(0, 0, 0, 1);
    @(negedge clk);
    chk("post_flush_pc", d_pc_o, 32'hBFC00040);
    chk("post_flush_pred", 32'(d_pred_taken_o), 1);
    step(0, 0, 0, 0);
    // full queue: pop proceeds, push refused
    for (int i = 0; i < 4; i++) step(1, 32'hBFC00400 + 32'(4 * i), 1, 0);
    step(1, 32'hBFC00500, 0, 1);
    @(negedge clk);
    chk("full_pop_ready", 32'(f_ready_o), 0);
    step(0, 0, 0, 0);
    @(negedge clk);
    chk("full_pop_count", 32'(count_o), 3);
    chk("full_pop_head", d_pc_o, 32'hBFC00404);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    // reset mid-operation at occupancy 2
    step(1, 32'hBFC00600, 1, 0);
    step(1, 32'hBFC00604, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0);
    @(negedge clk);
    chk("rst_count", 32'(count_o), 0);
    chk("rst_instr", d_instr_o, 32'h00000013);
    chk("rst_pc", d_pc_o, 0);
    chk("rst_ready", 32'(f_ready_o), 1);
    step(0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Decoupling instruction queue between the fetch stage and the decode stage. It buffers up to DEPTH fetched instruction packets: instruction, PC, PC+4 and the predictor's taken bit. Fetch keeps running while decode is stalled, and the whole queue is discarded in one cycle on an Execute-stage mispredict. Fetch's StallF is driven from `!f_ready_o`. Decode consumes the head packet under a valid/ready handshake.

## Interface
- DATA_WIDTH, 32, width of instruction and address fields
- DEPTH, 4, number of entries; power of two, ≥2

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush_i  in  1  mispredict correction from Execute (PCSrc); empties the queue
- f_valid_i  in  1  fetch presents a packet this cycle
- f_instr_i  in  DATA_WIDTH  fetched instruction
- f_pc_i  in  DATA_WIDTH  PC of the instruction
- f_pcplus4_i  in  DATA_WIDTH  PC+4
- f_pred_taken_i  in  1  predictor taken bit for this PC
- f_ready_o  out  1  queue can accept a push (= not full)
- d_valid_o  out  1  head packet valid
- d_ready_i  in  1  decode accepts head (= !StallD)
- d_instr_o  out  DATA_WIDTH  head instruction (NOP 32'h00000013 when empty)
- d_pc_o, d_pcplus4_o  out  DATA_WIDTH  head PC / PC+4 (0 when empty)
- d_pred_taken_o  out  1  head predict bit (0 when empty)
- d_rs1_o, d_rs2_o, d_rd_o  out  5  fields [19:15], [24:20], [11:7] of d_instr_o
- count_o  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Circular buffer: wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits wide, with the extra bit used as the wrap flag.
- empty = (wr_ptr == rd_ptr).
- full = index bits equal and wrap bits differ.
- push = f_valid_i & f_ready_o. It writes the entry at wr_ptr, then wr_ptr increments.
- pop = d_valid_o & d_ready_i. rd_ptr increments.
- f_ready_o = !full. There is no push-through when full, even if a pop occurs the same cycle. This keeps the path from d_ready_i to f_ready_o free of combinational logic.
- d_valid_o = !empty. There is no bypass, so a packet pushed into an empty queue is not visible until the next cycle.
- Simultaneous push and pop when neither full nor empty: both pointers advance and count is unchanged.
- count_o = wr_ptr − rd_ptr (modulo 2^(ptr width)). It must equal DEPTH when full.
- Pointer wrap from DEPTH−1 to 0 toggles the wrap bit. Entry contents never need clearing.
- Head outputs are read combinationally from the entry at rd_ptr. When empty they are forced to the NOP/0 values.
- flush_i has priority over push and pop:
  - pointers reset to 0, count to 0;
  - the same-cycle push is discarded;
  - the same-cycle pop has no effect;
  - the next cycle shows d_valid_o=0 and f_ready_o=1.
- The first packet from the corrected PC (PCTargetE) arrives the cycle after flush and is accepted normally.
- rst behaves like flush. Asserting rst mid-operation discards all contents. rst overrides flush_i.

## Timing
- Reset values: f_ready_o=1, d_valid_o=0, d_instr_o=32'h00000013, d_pc_o=0, d_pcplus4_o=0, d_pred_taken_o=0, d_rs1/rs2/rd=0, count_o=0.
- Push-to-visible latency is 1 cycle: pushed at edge N, d_valid_o is high after edge N.
- f_ready_o and d_valid_o are functions of registered pointers only, with no combinational dependency on any input.
- Sustained throughput is 1 packet/cycle with simultaneous push and pop, including at occupancy 0 (push) and DEPTH (pop).
- After DEPTH pushes with no pop, f_ready_o goes low at the edge of the last push.

## Structure
- Package fetch_pkg holds:
  - localparam NOP_INSTR = 32'h00000013;
  - typedef struct packed fetch_pkt_t {instr, pc, pcplus4, pred_taken};
  - the field-slice constants for rs1/rs2/rd.
- Storage is an array of fetch_pkt_t. The design is flat with no sub-module; the pointer/flag logic is small enough to stay inline.

## Test plan
- Reset, then idle: d_valid_o=0, d_instr_o=32'h00000013, f_ready_o=1, count_o=0.
- Push PCs 0xBFC00000..0xBFC0000C with d_ready_i=0: count_o reaches 4 and f_ready_o=0. A fifth push is ignored. Raising d_ready_i then pops the packets in PC order, with d_pcplus4_o = PC+4.
- Continuous push and pop for 12 cycles from empty: each packet appears 1 cycle after its push, with no gaps or duplicates through the pointer wrap. count_o stays at 1.
- Occupancy 3, flush_i asserted together with f_valid_i and d_ready_i: the next cycle shows count_o=0 and d_valid_o=0. A push of PC 0xBFC00040 the cycle after is output with d_pred_taken_o preserved.
- Full queue with simultaneous pop and f_valid_i=1: the push is refused (f_ready_o=0 that cycle), the pop proceeds, and count_o becomes 3.
- rst asserted at occupancy 2 with flush_i=0: the queue empties and all outputs return to their reset values the next cycle.
